// File: rtl/div_sequencer.sv
// Control stage for the 24-bit sequential divider.
// It accepts an operand pair, runs the divider for a fixed count and returns the quotient.
module div_sequencer #(
    parameter int C_NUM_BITS   = 24,
    parameter int C_DIV_CYCLES = 32,
    parameter int C_CNT_BITS   = 6
) (
    input  logic                  CK,
    input  logic                  R,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [C_NUM_BITS-1:0] IN_A,
    input  logic [C_NUM_BITS-1:0] IN_B,
    output logic                  DIV_RN,
    output logic                  DIV_E,
    output logic [C_NUM_BITS-1:0] DIV_A,
    output logic [C_NUM_BITS-1:0] DIV_B,
    input  logic [C_NUM_BITS-1:0] DIV_Q,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [C_NUM_BITS-1:0] OUT_Q,
    output logic                  OUT_DZ,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        DONE
    } state_t;

    localparam logic [C_CNT_BITS-1:0] LastCount = C_CNT_BITS'(C_DIV_CYCLES - 1);

    state_t                  state_q;
    logic [C_CNT_BITS-1:0]   count_q;
    logic                    divRn_q;
    logic                    divE_q;
    logic [C_NUM_BITS-1:0]   divA_q;
    logic [C_NUM_BITS-1:0]   divB_q;
    logic                    outValid_q;
    logic [C_NUM_BITS-1:0]   outQ_q;
    logic                    outDz_q;

    // Divider pins are set on the edge entering a state, so they line up with it.
    // OUT_VALID rises one cycle after DONE is entered, once the quotient has settled.
    always_ff @(posedge CK) begin
        if (R) begin
            state_q    <= IDLE;
            count_q    <= '0;
            divRn_q    <= 1'b0;
            divE_q     <= 1'b0;
            divA_q     <= '0;
            divB_q     <= '0;
            outValid_q <= 1'b0;
            outQ_q     <= '0;
            outDz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    divRn_q <= 1'b1;
                    divE_q  <= 1'b0;
                    if (IN_VALID) begin
                        divA_q <= IN_A;
                        divB_q <= IN_B;
                        if (IN_B == '0) begin
                            state_q <= DONE;
                            outQ_q  <= '1;
                            outDz_q <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                            divRn_q <= 1'b0;
                            divE_q  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_q <= RUN;
                    count_q <= '0;
                    divRn_q <= 1'b1;
                    divE_q  <= 1'b1;
                end
                RUN: begin
                    if (count_q == LastCount) begin
                        state_q <= SETTLE;
                        divE_q  <= 1'b0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                SETTLE: begin
                    state_q <= DONE;
                    outQ_q  <= DIV_Q;
                    outDz_q <= 1'b0;
                end
                DONE: begin
                    if (outValid_q && OUT_READY) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                    end else begin
                        outValid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign DIV_RN    = divRn_q;
    assign DIV_E     = divE_q;
    assign DIV_A     = divA_q;
    assign DIV_B     = divB_q;
    assign OUT_VALID = outValid_q;
    assign OUT_Q     = outQ_q;
    assign OUT_DZ    = outDz_q;

endmodule
